cordic_twiddle_seq: RTL

Folded twiddle-rotation sequencer for the 256-point FFT. It accepts one complex sample and a 7-bit twiddle index, maps the index to a CORDIC angle with quadrant pre-rotation, and steps a single combinational CORDIC iteration cell through 16 iterations, one per clock. The rotated sample is returned over a valid/ready handshake. It sits between the butterfly output and the next FFT stage and replaces the unrolled 16-cell rotator where area matters more than throughput.

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_iter.sv | 42 ++++
 rtl/cordic_twiddle_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the folded twiddle rotator.
//   - DW / ITER / KW / IW : data width, iteration count, twiddle index width,
//                           iteration counter width
//   - ANGLE_STEP          : one twiddle step (360/256 deg) in 1/256-degree units
//   - ANGLE_90            : 90 degrees in 1/256-degree units
//   - ATAN_TABLE          : atan(2^-i) in 1/256-degree units, i = 0..15
//   - state_e             : sequencer FSM states
package cordic_pkg;

  localparam int DW   = 16;
  localparam int ITER = 16;
  localparam int KW   = 7;
  localparam int IW   = 4;

  localparam logic signed [DW-1:0] ANGLE_STEP = 16'sd360;
  localparam logic signed [DW-1:0] ANGLE_90   = 16'sd23040;

  localparam logic signed [DW-1:0] ATAN_TABLE [ITER] = '{
    16'sd11520, 16'sd6801, 16'sd3593, 16'sd1824,
    16'sd915,   16'sd458,  16'sd229,  16'sd115,
    16'sd57,    16'sd29,   16'sd14,   16'sd7,
    16'sd4,     16'sd2,    16'sd1,    16'sd0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic signed [DW-1:0] atan_lut(input logic [IW-1:0] idx);
    return ATAN_TABLE[idx];
  endfunction

endpackage

// File: rtl/cordic_iter.sv
// cordic_iter: one combinational CORDIC rotation-mode iteration.
//   x_i, y_i, z_i : current vector and residual angle (signed, DW bits)
//   index_i       : iteration number, used as the shift amount
//   rota_i        : atan(2^-index) for this iteration
//   x_o, y_o, z_o : vector and residual angle after the micro-rotation
// A negative residual angle rotates clockwise, otherwise counter-clockwise.
// Both vector updates use the incoming x/y; all arithmetic wraps at DW bits.
module cordic_iter
  import cordic_pkg::*;
(
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  input  logic        [IW-1:0] index_i,
  input  logic signed [DW-1:0] rota_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [DW-1:0] z_o
);

  logic signed [DW-1:0] x_sh;
  logic signed [DW-1:0] y_sh;

  assign x_sh = x_i >>> index_i;
  assign y_sh = y_i >>> index_i;

  always_comb begin
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (z_i[DW-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + rota_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - rota_i;
    end
  end

endmodule

// File: rtl/cordic_twiddle_seq.sv
// cordic_twiddle_seq: folded twiddle rotator for the 256-point FFT.
// Accepts one complex sample plus twiddle index k, rotates it by -360*k/256
// degrees using one CORDIC cell stepped over 16 clocks, and returns the
// result (scaled by the CORDIC gain, uncompensated).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake
//   in_real, in_img     : signed input sample (|v| <= 9000)
//   in_k                : twiddle index 0..127
//   out_valid/out_ready : output handshake
//   out_real, out_img   : rotated sample, held while out_valid is high
//   busy                : high while rotating or holding a result
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are decoded purely from the state
// register; a producer holds its data steady until the transfer occurs.
module cordic_twiddle_seq
  import cordic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_img,
  input  logic        [KW-1:0] in_k,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_img,
  output logic                 busy,
  output state_e               dbg_state
);

  localparam logic [IW-1:0] ITER_LAST = IW'(ITER - 1);

  state_e               state_q;
  logic        [IW-1:0] iter_q;
  logic signed [DW-1:0] x_q, y_q, z_q;
  logic signed [DW-1:0] out_real_q, out_img_q;

  // Next-state values produced by the iteration cell.
  logic signed [DW-1:0] x_d, y_d, z_d;

  // Load values after quadrant pre-rotation.
  logic signed [DW-1:0] x_load, y_load, z_load;
  logic        [DW-1:0] k_low;

  // Indices 64..127 get a fixed -90 degree swap first, so the residual angle
  // only has to cover (-90, 0] degrees, well inside CORDIC convergence.
  // The residual index is k mod 64 in both halves.
  assign k_low = {{(DW-KW+1){1'b0}}, in_k[KW-2:0]};

  always_comb begin
    z_load = $signed(DW'(0) - (k_low * ANGLE_STEP));
    if (in_k[KW-1]) begin
      x_load = in_img;
      y_load = -in_real;
    end else begin
      x_load = in_real;
      y_load = in_img;
    end
  end

  cordic_iter u_iter (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .index_i (iter_q),
    .rota_i  (atan_lut(iter_q)),
    .x_o     (x_d),
    .y_o     (y_d),
    .z_o     (z_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      iter_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      out_real_q <= '0;
      out_img_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= x_load;
            y_q     <= y_load;
            z_q     <= z_load;
            iter_q  <= '0;
            state_q <= ST_ROT;
          end
        end
        ST_ROT: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 1'b1;
          // Last iteration: capture the result straight from the cell.
          if (iter_q == ITER_LAST) begin
            out_real_q <= x_d;
            out_img_q  <= y_d;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_real  = out_real_q;
  assign out_img   = out_img_q;
  assign dbg_state = state_q;

endmodule
